pipeexe_md: RTL and testbench
=============================

# pipeexe_md

Parametrised execute stage for the five-stage pipelined MIPS CPU, the successor to the single-cycle EXE stage. It keeps the single-cycle ALU, shift-amount, immediate and link paths. It adds an iterative, non-blocking multiply/divide unit that owns the HI/LO registers, and it raises a stall to the pipeline control when a later HI/LO instruction reaches EXE while that unit is still busy. It sits between the ID/EXE and EXE/MEM pipeline registers.

## Interface
- XLEN, 32, datapath width; must be even and at least 8.
- RW, 5, register-number width.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ein_valid  in  1  a valid instruction occupies EXE this cycle.
- ealuc  in  5  ALU operation; encoding unchanged from the `alu` unit.
- ealuimm, eshift, ejal, ejalr  in  1 each  operand-B immediate select, shift select, jal, jalr.
- emdop  in  4  multiply/divide operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 behave as 0.
- ea, eb, eimm, epc4  in  XLEN each  operand A, operand B, extended immediate, PC+4.
- ern0  in  RW  destination register number.
- ealu  out  XLEN  EXE result (combinational).
- ern  out  RW  final destination: ern0 OR all-ones when ejal.
- estall  out  1  hold IF/ID/EXE and inject a bubble into MEM.
- md_busy  out  1  iteration in progress.
- hi, lo  out  XLEN each  architectural HI and LO registers.

## Operation
- ALU operand A: `eshift` ? zero-extended eimm[10:6] : ea. Operand B: `ealuimm` ? eimm : eb. The ALU is the codebase `alu`, carried at width XLEN; its 64-bit mult output is unused.
- ealu priority, first match wins:
  - ejal|ejalr → epc4+4 (return past the delay slot).
  - emdop=5 → hi.
  - emdop=6 → lo.
  - otherwise → ALU result.
- FSM states:
  - IDLE → MUL on an issued mult/multu.
  - IDLE → DIV on an issued div/divu.
  - MUL/DIV → IDLE when the counter reaches 0.
- Issue: `ein_valid` & emdop∈{1..4} & state IDLE. On issue:
  - Latch |ea| and |eb| for signed ops, or raw ea and eb for unsigned ops.
  - Latch the result-sign flags.
  - Load the counter with XLEN.
- The issuing instruction does not stall.
- Iteration, one per cycle:
  - MUL: radix-2 shift-add over a 2·XLEN accumulator.
  - DIV: restoring shift-subtract producing a quotient and a remainder.
- Completion, in the cycle the counter goes 1→0:
  - Apply signs: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Write HI and LO: HI = product high half or remainder; LO = product low half or quotient.
- Division by zero: LO = all-ones, HI = dividend (signed or unsigned as issued).
- Signed MIN/−1: LO = MIN, HI = 0.
- mthi/mtlo in IDLE with `ein_valid`: HI or LO ← ea at the clock edge.
- estall = `ein_valid` & emdop∈{1..8} & state≠IDLE. The stalled instruction re-presents its inputs every cycle until estall=0.
- Non-HI/LO instructions never stall.

## Timing
- Reset (synchronous): state IDLE, counter 0, hi=0, lo=0, md_busy=0, estall=0.
  - Reset mid-iteration abandons the operation.
  - HI/LO are not updated by the abandoned operation.
- Issue at edge N: md_busy=1 during cycles N+1 … N+XLEN.
- HI/LO new values are visible from cycle N+XLEN+1.
  - An mfhi arriving in that cycle or later reads the new value without stalling.
  - An mfhi arriving in cycles N+1 … N+XLEN stalls until cycle N+XLEN+1.
- An md op presented when state is IDLE is never stalled, including in the cycle md_busy falls.
- HI/LO do not forward the in-flight result; mfhi/mflo read the registered value.
- ALU and link paths are combinational, with zero added latency.

## Configuration
- PIPEEXE_DIV_EN defined: div/divu are issued as described above.
- PIPEEXE_DIV_EN undefined: the DIV state and divide datapath are omitted.
  - emdop 3/4 are treated as 0: no busy, no stall, HI/LO unchanged.
  - mult/multu and mfhi/mflo/mthi/mtlo are unaffected.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → md_busy for 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
- mult −3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. div −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x00001234. div 0x80000000 / −1 → lo=0x80000000, hi=0.
- mult issued, then mflo presented 3 cycles later → estall=1 until the cycle after the last busy cycle; ealu then equals the new lo. An addu presented while busy → estall=0.
- reset at busy cycle 10 → md_busy=0 next cycle, hi=lo=0, and a following mfhi returns 0 without stalling.
- jal with epc4=0x00400008 → ealu=0x0040000C, ern=31. Build without PIPEEXE_DIV_EN, issue div → no busy, hi/lo unchanged.

Source files
------------

// File: rtl/pipeexe_md.sv
// EXE stage for the five-stage MIPS pipeline: ALU, shift, immediate and link paths plus an
// iterative mult/div unit that owns HI/LO. Optional divider is built when PIPEEXE_DIV_EN is defined.

module alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      aluc,
    output logic [XLEN-1:0] r
);
    localparam int SW = $clog2(XLEN);

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_NOR  = 5'd5;
    localparam logic [4:0] ALU_SLT  = 5'd6;
    localparam logic [4:0] ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8;
    localparam logic [4:0] ALU_SRL  = 5'd9;
    localparam logic [4:0] ALU_SRA  = 5'd10;
    localparam logic [4:0] ALU_LUI  = 5'd11;

    logic [SW-1:0] sa;
    assign sa = a[SW-1:0];

    always_comb begin
        r = a + b;
        case (aluc)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_NOR:  r = ~(a | b);
            ALU_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SLL:  r = b << sa;
            ALU_SRL:  r = b >> sa;
            ALU_SRA:  r = $signed(b) >>> sa;
            ALU_LUI:  r = {b[XLEN/2-1:0], {(XLEN/2){1'b0}}};
            default:  r = a + b;
        endcase
    end
endmodule

// state | meaning
// IDLE  | no iteration in flight; md ops issue, mthi/mtlo write
// MUL   | shift-add multiply, one bit per cycle
// DIV   | restoring divide, one bit per cycle (PIPEEXE_DIV_EN only)
module pipeexe_md #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ein_valid,
    input  logic [4:0]      ealuc,
    input  logic            ealuimm,
    input  logic            eshift,
    input  logic            ejal,
    input  logic            ejalr,
    input  logic [3:0]      emdop,
    input  logic [XLEN-1:0] ea,
    input  logic [XLEN-1:0] eb,
    input  logic [XLEN-1:0] eimm,
    input  logic [XLEN-1:0] epc4,
    input  logic [RW-1:0]   ern0,
    output logic [XLEN-1:0] ealu,
    output logic [RW-1:0]   ern,
    output logic            estall,
    output logic            md_busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
`ifdef PIPEEXE_DIV_EN
        ,S_DIV = 2'd2
`endif
    } state_t;

    state_t state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [2*XLEN-1:0] acc, acc_nxt;
    logic [XLEN-1:0]   opb, opb_nxt;
    logic [XLEN-1:0]   hi_nxt, lo_nxt;
    logic              neg_q, neg_q_nxt;

    logic op_mul, op_div, op_signed, op_hilo, idle, issue;
    logic [XLEN-1:0] a_abs, b_abs;

    logic [XLEN-1:0]   alu_a, alu_b, alu_r;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, prod;

    assign op_mul    = (emdop == 4'd1) || (emdop == 4'd2);
    assign op_signed = (emdop == 4'd1) || (emdop == 4'd3);
`ifdef PIPEEXE_DIV_EN
    assign op_div    = (emdop == 4'd3) || (emdop == 4'd4);
`else
    assign op_div    = 1'b0;
`endif
    assign op_hilo = op_mul || op_div || ((emdop >= 4'd5) && (emdop <= 4'd8));
    assign idle    = (state == S_IDLE);
    assign issue   = ein_valid && idle && (op_mul || op_div);

    assign md_busy = !idle;
    assign estall  = ein_valid && op_hilo && !idle;

    assign a_abs = (op_signed && ea[XLEN-1]) ? -ea : ea;
    assign b_abs = (op_signed && eb[XLEN-1]) ? -eb : eb;

    // Shift amount comes from the instruction's sa field, eimm[10:6].
    assign alu_a = eshift ? ((eimm >> 6) & XLEN'(5'h1f)) : ea;
    assign alu_b = ealuimm ? eimm : eb;

    alu #(.XLEN(XLEN)) u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .aluc (ealuc),
        .r    (alu_r)
    );

    always_comb begin
        ealu = alu_r;
        if (ejal || ejalr)
            ealu = epc4 + XLEN'(4);
        else if (emdop == 4'd5)
            ealu = hi;
        else if (emdop == 4'd6)
            ealu = lo;
    end

    assign ern = ern0 | {RW{ejal}};

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    assign mul_step = {mul_sum, acc[XLEN-1:1]};
    assign prod     = neg_q ? -mul_step : mul_step;

`ifdef PIPEEXE_DIV_EN
    logic              neg_r, neg_r_nxt;
    logic [XLEN:0]     trial;
    logic              div_ge;
    logic [XLEN-1:0]   rem_new, quo_fin, rem_fin;
    logic [2*XLEN-1:0] div_step;

    // Divide by zero falls out naturally: quotient all-ones, remainder = dividend.
    assign trial    = acc[2*XLEN-1:XLEN-1];
    assign div_ge   = (trial >= {1'b0, opb});
    assign rem_new  = div_ge ? (trial[XLEN-1:0] - opb) : trial[XLEN-1:0];
    assign div_step = {rem_new, acc[XLEN-2:0], div_ge};
    assign quo_fin  = neg_q ? -div_step[XLEN-1:0] : div_step[XLEN-1:0];
    assign rem_fin  = neg_r ? -div_step[2*XLEN-1:XLEN] : div_step[2*XLEN-1:XLEN];
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        opb_nxt   = opb;
        hi_nxt    = hi;
        lo_nxt    = lo;
        neg_q_nxt = neg_q;
`ifdef PIPEEXE_DIV_EN
        neg_r_nxt = neg_r;
`endif
        case (state)
            S_IDLE: begin
                if (issue) begin
                    acc_nxt   = {{XLEN{1'b0}}, a_abs};
                    opb_nxt   = b_abs;
                    cnt_nxt   = CW'(XLEN);
                    // A zero divisor keeps the all-ones quotient unsigned.
                    neg_q_nxt = op_signed && (ea[XLEN-1] ^ eb[XLEN-1]) && (op_mul || (|eb));
`ifdef PIPEEXE_DIV_EN
                    neg_r_nxt = op_signed && ea[XLEN-1];
                    state_nxt = op_mul ? S_MUL : S_DIV;
`else
                    state_nxt = S_MUL;
`endif
                end else if (ein_valid && (emdop == 4'd7)) begin
                    hi_nxt = ea;
                end else if (ein_valid && (emdop == 4'd8)) begin
                    lo_nxt = ea;
                end
            end
            S_MUL: begin
                acc_nxt = mul_step;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = S_IDLE;
                    hi_nxt    = prod[2*XLEN-1:XLEN];
                    lo_nxt    = prod[XLEN-1:0];
                end
            end
`ifdef PIPEEXE_DIV_EN
            S_DIV: begin
                acc_nxt = div_step;
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = S_IDLE;
                    hi_nxt    = rem_fin;
                    lo_nxt    = quo_fin;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
            opb   <= '0;
            hi    <= '0;
            lo    <= '0;
            neg_q <= 1'b0;
`ifdef PIPEEXE_DIV_EN
            neg_r <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            opb   <= opb_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            neg_q <= neg_q_nxt;
`ifdef PIPEEXE_DIV_EN
            neg_r <= neg_r_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_pipeexe_md.sv
// Self-checking bench for pipeexe_md: cycle-level HI/LO model plus directed literal checks.
module tb_pipeexe_md;
    logic        clock = 1'b0;
    logic        reset;
    logic        ein_valid;
    logic [4:0]  ealuc;
    logic        ealuimm, eshift, ejal, ejalr;
    logic [3:0]  emdop;
    logic [31:0] ea, eb, eimm, epc4;
    logic [4:0]  ern0;
    logic [31:0] ealu;
    logic [4:0]  ern;
    logic        estall, md_busy;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_left = 0;

    pipeexe_md #(.XLEN(32), .RW(5)) dut (
        .clock(clock), .reset(reset), .ein_valid(ein_valid), .ealuc(ealuc),
        .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal), .ejalr(ejalr),
        .emdop(emdop), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern0(ern0),
        .ealu(ealu), .ern(ern), .estall(estall), .md_busy(md_busy), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit md_op(input logic [3:0] m);
`ifdef PIPEEXE_DIV_EN
        return (m >= 4'd1) && (m <= 4'd8);
`else
        return (m >= 4'd1) && (m <= 4'd8) && (m != 4'd3) && (m != 4'd4);
`endif
    endfunction

    function automatic logic [31:0] alu_ref(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return ~(a | b);
            5'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7:  return (a < b) ? 32'd1 : 32'd0;
            5'd8:  return b << a[4:0];
            5'd9:  return b >> a[4:0];
            5'd10: return $signed(b) >>> a[4:0];
            5'd11: return {b[15:0], 16'h0};
            default: return a + b;
        endcase
    endfunction

    // Architectural model: results via plain arithmetic, busy as a cycle count.
    always @(posedge clock) begin
        longint      sp;
        logic [63:0] up;
        int          si_a, si_b;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else if (ein_valid) begin
            case (emdop)
                4'd1: begin sp = longint'($signed(ea)) * longint'($signed(eb)); {p_hi, p_lo} = sp; m_left = 32; end
                4'd2: begin up = {32'h0, ea} * {32'h0, eb}; {p_hi, p_lo} = up; m_left = 32; end
`ifdef PIPEEXE_DIV_EN
                4'd3: begin
                    if (eb == 0) begin p_lo = '1; p_hi = ea; end
                    else if (ea == 32'h80000000 && eb == 32'hFFFFFFFF) begin p_lo = ea; p_hi = 0; end
                    else begin si_a = ea; si_b = eb; p_lo = si_a / si_b; p_hi = si_a % si_b; end
                    m_left = 32;
                end
                4'd4: begin
                    if (eb == 0) begin p_lo = '1; p_hi = ea; end
                    else begin p_lo = ea / eb; p_hi = ea % eb; end
                    m_left = 32;
                end
`endif
                4'd7: m_hi = ea;
                4'd8: m_lo = ea;
                default: ;
            endcase
        end
    end

    always @(negedge clock) begin
        logic [31:0] exp_alu, a_op, b_op;
        logic        exp_busy;
        if (chk_en) begin
            exp_busy = (m_left != 0);
            a_op = eshift ? {27'h0, eimm[10:6]} : ea;
            b_op = ealuimm ? eimm : eb;
            if (ejal || ejalr)      exp_alu = epc4 + 32'd4;
            else if (emdop == 4'd5) exp_alu = m_hi;
            else if (emdop == 4'd6) exp_alu = m_lo;
            else                    exp_alu = alu_ref(ealuc, a_op, b_op);
            chk("md_busy", {31'h0, md_busy}, {31'h0, exp_busy});
            chk("estall", {31'h0, estall}, {31'h0, ein_valid && md_op(emdop) && exp_busy});
            chk("ealu", ealu, exp_alu);
            chk("ern", {27'h0, ern}, {27'h0, ern0 | {5{ejal}}});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic set_in(input bit v, input logic [4:0] c, input bit imm_s, input bit sh,
                          input bit jal, input bit jalr, input logic [3:0] md,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic [31:0] pc4, input logic [4:0] rn);
        ein_valid = v; ealuc = c; ealuimm = imm_s; eshift = sh; ejal = jal; ejalr = jalr;
        emdop = md; ea = a; eb = b; eimm = imm; epc4 = pc4; ern0 = rn;
    endtask

    task automatic idle_in();
        set_in(0, 5'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 5'd0);
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        set_in(1, 5'd0, 0, 0, 0, 0, op, a, b, 0, 0, 5'd0);
        step();
        idle_in();
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (!md_busy) done = 1;
            else step();
        end
        chk("wait_idle", {31'h0, md_busy}, 32'h0);
    endtask

    initial begin
        int busy_cnt, stall_cnt;
        bit released;
        idle_in();
        reset = 1;
        step(); step();
        reset = 0;
        chk_en = 1;
        #1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'h0, md_busy}, 32'h0);
        step();

        // ALU and link paths
        set_in(1, 5'd0, 0, 0, 0, 0, 4'd0, 32'd5, 32'd7, 0, 0, 5'd3);  #1; chk("addu", ealu, 32'd12); step();
        set_in(1, 5'd1, 0, 0, 0, 0, 4'd0, 32'd10, 32'd3, 0, 0, 5'd4); #1; chk("subu", ealu, 32'd7); step();
        set_in(1, 5'd8, 0, 1, 0, 0, 4'd0, 32'hFFFF, 32'h3, 32'h100, 0, 5'd5); #1; chk("sll", ealu, 32'h30); step();
        set_in(1, 5'd10, 0, 1, 0, 0, 4'd0, 0, 32'hFFFFFF00, 32'h80, 0, 5'd6); #1; chk("sra", ealu, 32'hFFFFFFC0); step();
        set_in(1, 5'd11, 1, 0, 0, 0, 4'd0, 0, 0, 32'h1234, 0, 5'd7); #1; chk("lui", ealu, 32'h12340000); step();
        set_in(1, 5'd6, 0, 0, 0, 0, 4'd0, 32'hFFFFFFFF, 32'd1, 0, 0, 5'd8); #1; chk("slt", ealu, 32'd1); step();
        set_in(1, 5'd0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 32'h00400008, 5'd0); #1;
        chk("jal_alu", ealu, 32'h0040000C); chk("jal_rn", {27'h0, ern}, 32'd31); step();
        idle_in();

        // multu all-ones
        md(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1; if (md_busy) busy_cnt++;
            step();
        end
        chk("multu_busy_cycles", busy_cnt, 32'd32);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        // mult -3*5, addu while busy, then mflo stalls until the result lands
        md(4'd1, 32'hFFFFFFFD, 32'd5);
        set_in(1, 5'd0, 0, 0, 0, 0, 4'd0, 32'd1, 32'd2, 0, 0, 5'd9); #1;
        chk("addu_busy_nostall", {31'h0, estall}, 32'h0);
        step();
        idle_in(); step();
        set_in(1, 5'd0, 0, 0, 0, 0, 4'd6, 0, 0, 0, 0, 5'd10);
        stall_cnt = 0; released = 0;
        for (int i = 0; i < 60 && !released; i++) begin
            #1;
            if (!estall) released = 1;
            else begin stall_cnt++; step(); end
        end
        chk("mflo_released", {31'h0, released}, 32'h1);
        chk("mflo_stall_cycles", stall_cnt, 32'd30);
        chk("mflo_value", ealu, 32'hFFFFFFF1);
        step();
        set_in(1, 5'd0, 0, 0, 0, 0, 4'd5, 0, 0, 0, 0, 5'd11); #1;
        chk("mfhi_value", ealu, 32'hFFFFFFFF);
        step();

        // mthi / mtlo
        set_in(1, 5'd0, 0, 0, 0, 0, 4'd7, 32'hAAAA5555, 0, 0, 0, 5'd0); step();
        set_in(1, 5'd0, 0, 0, 0, 0, 4'd8, 32'h12345678, 0, 0, 0, 5'd0); step();
        idle_in(); #1;
        chk("mthi", hi, 32'hAAAA5555);
        chk("mtlo", lo, 32'h12345678);
        step();

`ifdef PIPEEXE_DIV_EN
        md(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle();
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        md(4'd4, 32'h1234, 32'd0);
        wait_idle();
        chk("divu0_lo", lo, 32'hFFFFFFFF);
        chk("divu0_hi", hi, 32'h00001234);
        md(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        chk("divmin_lo", lo, 32'h80000000);
        chk("divmin_hi", hi, 32'h0);
`else
        md(4'd3, 32'd7, 32'd2);
        #1;
        chk("nodiv_busy", {31'h0, md_busy}, 32'h0);
        chk("nodiv_hi", hi, 32'hAAAA5555);
        chk("nodiv_lo", lo, 32'h12345678);
        step();
`endif

        // reset mid-iteration
        md(4'd2, 32'd7, 32'd9);
        repeat (9) step();
        #1; chk("pre_reset_busy", {31'h0, md_busy}, 32'h1);
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("rst_mid_busy", {31'h0, md_busy}, 32'h0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        step();
        set_in(1, 5'd0, 0, 0, 0, 0, 4'd5, 0, 0, 0, 0, 5'd2); #1;
        chk("rst_mfhi_stall", {31'h0, estall}, 32'h0);
        chk("rst_mfhi_val", ealu, 32'h0);
        step();
        idle_in();
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
